rfft_seq: RTL and testbench

RFFT_SEQ -- requirements
Module: rfft_seq

---
 rtl/rfft_seq_pkg.sv | 26 ++
 rtl/rfft_addr_gen.sv | 57 +++++
 rtl/rfft_seq.sv | 177 +++++++++++++++++
 tb/tb_rfft_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rfft_seq_pkg.sv
// rfft_seq shared types: FSM states, PE lane-map codes, size limits.
// Used by the sequencer top and its address generator.
package rfft_seq_pkg;

   localparam int MIN_LOG2N = 4;
   localparam int MAX_LOG2N = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_OUT
   } state_e;

   localparam logic [1:0] SEL_STRAIGHT = 2'd0;
   localparam logic [1:0] SEL_CROSS    = 2'd1;
   localparam logic [1:0] SEL_ROTA     = 2'd2;
   localparam logic [1:0] SEL_ROTB     = 2'd3;

   function automatic logic [3:0] clamp_l(logic [3:0] v, logic [3:0] hi);
      if (v < 4'(MIN_LOG2N)) return 4'(MIN_LOG2N);
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/rfft_addr_gen.sv
// rfft_addr_gen: combinational map from (stage, size, read/write row)
// to partner addresses, twiddle address and PE/RAM lane selects.
module rfft_addr_gen
   import rfft_seq_pkg::*;
#(
   parameter int LOG2N = 8,
   localparam int AW = LOG2N - 2
) (
   input  logic [3:0]       s_i,
   input  logic [3:0]       l_i,
   input  logic [AW-1:0]    r_i,
   input  logic [AW-1:0]    w_i,
   output logic [AW-1:0]    rd_addr1_o,
   output logic [AW-1:0]    wr_addr1_o,
   output logic [LOG2N-1:0] tf_addr_o,
   output logic [1:0]       rd_sel_o,
   output logic             wr_sel_o
);

   int            na;
   int            sv;
   logic [AW-1:0] mask;
   logic [AW-1:0] kmask;
   logic [AW-1:0] k;
   logic          top_zero;
   logic          rbit;
   logic          wbit;

   // Partner mask, twiddle index and lane selects for the current row
   always_comb begin
      na    = int'(l_i) - 2;
      sv    = int'(s_i);
      mask  = '0;
      kmask = '0;
      rbit  = 1'b0;
      wbit  = 1'b0;
      for (int i = 0; i < AW; i++) begin
         mask[i]  = (i < na) && (i + sv >= na);
         kmask[i] = (i < na - sv);
         if (i == na - sv) rbit = r_i[i];
         if (i == na - 1 - sv) wbit = w_i[i];
      end
      k          = r_i & kmask;
      top_zero   = ((r_i & mask) == '0);
      rd_addr1_o = r_i ^ mask;
      wr_addr1_o = w_i ^ mask;
      wr_sel_o   = wbit;
      if (sv >= na) tf_addr_o = '0;
      else if (top_zero) tf_addr_o = LOG2N'(k) << sv;
      else tf_addr_o = LOG2N'(k) << (sv + 1);
      if (sv == 0) rd_sel_o = SEL_CROSS;
      else if (top_zero) rd_sel_o = SEL_STRAIGHT;
      else if (rbit) rd_sel_o = SEL_ROTA;
      else rd_sel_o = SEL_ROTB;
   end

endmodule

// File: rtl/rfft_seq.sv
// rfft_seq: stage/row sequencer for an in-place radix-2 real FFT PE.
// RFFT_SEQ_BITREV_EN adds a bit-reversed readout phase before Done.
module rfft_seq
   import rfft_seq_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int LOG2N  = 8,
   parameter int PE_LAT = 2,
   localparam int AW = LOG2N - 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       Log2n,
   output logic             Busy,
   output logic             Done,
   output logic [AW-1:0]    Rd_addr0,
   output logic [AW-1:0]    Rd_addr1,
   output logic [AW-1:0]    Wr_addr0,
   output logic [AW-1:0]    Wr_addr1,
   output logic             Wr_en,
   output logic [LOG2N-1:0] Tf_addr,
   output logic             Bypass_n,
   output logic [1:0]       Rd_sel,
   output logic             Wr_sel,
   output logic [3:0]       Stage,
   output logic             Out_valid,
   output logic [AW-1:0]    Out_addr
);

   localparam int CW = LOG2N;

   if (WIDTH < 1 || LOG2N < MIN_LOG2N || LOG2N > MAX_LOG2N ||
       PE_LAT < 1 || PE_LAT > 8) begin : g_bad_param
      $error("rfft_seq: illegal parameter value");
   end

   state_e        state_q, state_d;
   logic [3:0]    l_q, l_d;
   logic [3:0]    s_q, s_d;
   logic [CW-1:0] t_q, t_d;
   logic          done_q, done_d;

   logic [CW-1:0]    m;
   logic [CW-1:0]    flush_end;
   logic             last_stage;
   logic             rd_act;
   logic             wr_act;
   logic [AW-1:0]    r;
   logic [AW-1:0]    w;
   logic [AW-1:0]    ag_rd1;
   logic [AW-1:0]    ag_wr1;
   logic [LOG2N-1:0] ag_tf;
   logic [1:0]       ag_rdsel;
   logic             ag_wrsel;

   assign m          = CW'(1) << (l_q - 4'd2);
   assign flush_end  = m + CW'(PE_LAT - 1);
   assign last_stage = (s_q == l_q - 4'd2);
   assign rd_act     = (state_q == ST_RUN);
   assign wr_act     = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
                       (t_q >= CW'(PE_LAT));
   assign r          = t_q[AW-1:0];
   assign w          = AW'(t_q - CW'(PE_LAT));

   rfft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .s_i        (s_q),
      .l_i        (l_q),
      .r_i        (r),
      .w_i        (w),
      .rd_addr1_o (ag_rd1),
      .wr_addr1_o (ag_wr1),
      .tf_addr_o  (ag_tf),
      .rd_sel_o   (ag_rdsel),
      .wr_sel_o   (ag_wrsel)
   );

   // State, size, stage and cycle counter registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         l_q     <= 4'(MIN_LOG2N);
         s_q     <= '0;
         t_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         s_q     <= s_d;
         t_q     <= t_d;
         done_q  <= done_d;
      end
   end

   // Next-state: rows of a stage, PE drain, then next stage or finish
   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      s_d     = s_q;
      t_d     = t_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d = ST_RUN;
               l_d     = clamp_l(Log2n, 4'(LOG2N));
               s_d     = '0;
               t_d     = '0;
            end
         end
         ST_RUN: begin
            t_d = t_q + CW'(1);
            if (t_q == m - CW'(1)) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            t_d = t_q + CW'(1);
            if (t_q == flush_end) begin
               t_d = '0;
               if (!last_stage) begin
                  s_d     = s_q + 4'd1;
                  state_d = ST_RUN;
               end else begin
`ifdef RFFT_SEQ_BITREV_EN
                  state_d = ST_OUT;
`else
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
`endif
               end
            end
         end
         ST_OUT: begin
            t_d = t_q + CW'(1);
            if (t_q == m - CW'(1)) begin
               t_d     = '0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode, gated so idle/inactive fields read 0
   always_comb begin
      Busy     = (state_q != ST_IDLE) || done_q;
      Done     = done_q;
      Stage    = (state_q == ST_IDLE) ? 4'd0 : s_q;
      Bypass_n = !(((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
                   last_stage);
      Rd_addr0 = rd_act ? r : '0;
      Rd_addr1 = rd_act ? ag_rd1 : '0;
      Tf_addr  = rd_act ? ag_tf : '0;
      Rd_sel   = rd_act ? ag_rdsel : SEL_STRAIGHT;
      Wr_en    = wr_act;
      Wr_addr0 = wr_act ? w : '0;
      Wr_addr1 = wr_act ? ag_wr1 : '0;
      Wr_sel   = wr_act ? ag_wrsel : 1'b0;
   end

`ifdef RFFT_SEQ_BITREV_EN
   // Readout strobe with bit-reversed row address over L-2 bits
   always_comb begin
      Out_valid = (state_q == ST_OUT);
      Out_addr  = '0;
      if (state_q == ST_OUT) begin
         for (int j = 0; j < AW; j++) begin
            if (j < int'(l_q) - 2) Out_addr[j] = r[int'(l_q) - 3 - j];
         end
      end
   end
`else
   assign Out_valid = 1'b0;
   assign Out_addr  = '0;
`endif

endmodule

// File: tb/tb_rfft_seq.sv
// Scoreboard bench for rfft_seq: per-cycle expected output vectors
// come from an arithmetic model of the address/lane rules.
module tb_rfft_seq;

   localparam int LOG2N = 8;
   localparam int PE    = 2;
   localparam int AW    = LOG2N - 2;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          wr_en;
      logic          byp;
      logic          wr_sel;
      logic [1:0]    rd_sel;
      logic [3:0]    stage;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [AW-1:0] wa0;
      logic [AW-1:0] wa1;
      logic [LOG2N-1:0] tf;
      logic          ov;
      logic [AW-1:0] oa;
   } ov_t;

   logic             clk = 1'b0;
   logic             Reset, Start;
   logic [3:0]       Log2n;
   logic             Busy, Done, Wr_en, Bypass_n, Wr_sel, Out_valid;
   logic [AW-1:0]    Rd_addr0, Rd_addr1, Wr_addr0, Wr_addr1, Out_addr;
   logic [LOG2N-1:0] Tf_addr;
   logic [1:0]       Rd_sel;
   logic [3:0]       Stage;

   ov_t q[$];
   int  dq[$];
   int  cyc = 0;
   int  n_pass = 0;
   int  n_tot = 0;
   bit  mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rfft_seq #(.WIDTH(16), .LOG2N(LOG2N), .PE_LAT(PE)) dut (
      .Clk(clk), .Reset(Reset), .Start(Start), .Log2n(Log2n),
      .Busy(Busy), .Done(Done),
      .Rd_addr0(Rd_addr0), .Rd_addr1(Rd_addr1),
      .Wr_addr0(Wr_addr0), .Wr_addr1(Wr_addr1), .Wr_en(Wr_en),
      .Tf_addr(Tf_addr), .Bypass_n(Bypass_n), .Rd_sel(Rd_sel),
      .Wr_sel(Wr_sel), .Stage(Stage),
      .Out_valid(Out_valid), .Out_addr(Out_addr)
   );

   function automatic ov_t sample();
      ov_t o;
      o.busy = Busy; o.done = Done; o.wr_en = Wr_en;
      o.byp = Bypass_n; o.wr_sel = Wr_sel; o.rd_sel = Rd_sel;
      o.stage = Stage; o.ra0 = Rd_addr0; o.ra1 = Rd_addr1;
      o.wa0 = Wr_addr0; o.wa1 = Wr_addr1; o.tf = Tf_addr;
      o.ov = Out_valid; o.oa = Out_addr;
      return o;
   endfunction

   function automatic ov_t idle_v();
      ov_t v = '0;
      v.byp = 1'b1;
      return v;
   endfunction

   task automatic check(string name, logic [127:0] got, logic [127:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
   endtask

   // Expected outputs for a whole transform of size L from the rules
   task automatic push_model(int L, int c1);
      int na = L - 2;
      int m = 1 << na;
      int mask, r, w, top, k, tf;
      ov_t v;
      for (int s = 0; s <= na; s++) begin
         mask = ((1 << s) - 1) << (na - s);
         for (int c = 0; c < m + PE; c++) begin
            v = '0;
            v.busy = 1'b1;
            v.stage = 4'(s);
            v.byp = (s == na) ? 1'b0 : 1'b1;
            if (c < m) begin
               r = c;
               top = r >> (na - s);
               k = r & ((1 << (na - s)) - 1);
               if (s == 0) tf = r;
               else if (s == na) tf = 0;
               else if (top == 0) tf = k << s;
               else tf = k << (s + 1);
               v.ra0 = AW'(r);
               v.ra1 = AW'(r ^ mask);
               v.tf = LOG2N'(tf);
               if (s == 0) v.rd_sel = 2'd1;
               else if (top == 0) v.rd_sel = 2'd0;
               else if (((r >> (na - s)) & 1) == 1) v.rd_sel = 2'd2;
               else v.rd_sel = 2'd3;
            end
            if (c >= PE) begin
               w = c - PE;
               v.wr_en = 1'b1;
               v.wa0 = AW'(w);
               v.wa1 = AW'(w ^ mask);
               v.wr_sel = (s < na) ? 1'((w >> (na - 1 - s)) & 1) : 1'b0;
            end
            q.push_back(v);
         end
      end
`ifdef RFFT_SEQ_BITREV_EN
      for (int c = 0; c < m; c++) begin
         v = '0;
         v.busy = 1'b1;
         v.stage = 4'(na);
         v.byp = 1'b1;
         v.ov = 1'b1;
         for (int j = 0; j < na; j++)
            if (((c >> j) & 1) == 1) v.oa[na - 1 - j] = 1'b1;
         q.push_back(v);
      end
      dq.push_back(c1 + (L - 1) * (m + PE) + m);
`else
      dq.push_back(c1 + (L - 1) * (m + PE));
`endif
      v = idle_v();
      v.busy = 1'b1;
      v.done = 1'b1;
      q.push_back(v);
   endtask

   // Monitor: compare every cycle against the scoreboard head
   always @(negedge clk) begin
      ov_t got, exp;
      if (mon_en) begin
         got = sample();
         exp = (q.size() > 0) ? q.pop_front() : idle_v();
         check("outputs", 128'(got), 128'(exp));
         if (got.done === 1'b1) begin
            if (dq.size() > 0) check("done_cycle", 128'(cyc), 128'(dq.pop_front()));
            else check("done_unexpected", 128'(1), 128'(0));
         end
      end
   end

   task automatic start_xfer(logic [3:0] v);
      int L = (v < 4) ? 4 : (v > LOG2N) ? LOG2N : int'(v);
      @(posedge clk); #1;
      Start = 1'b1; Log2n = v;
      @(posedge clk); #1;
      Start = 1'b0;
      Log2n = 4'($urandom_range(0, 15));
      push_model(L, cyc);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((q.size() > 0 || dq.size() > 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 3000) check("timeout", 128'(q.size()), 128'(0));
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Log2n = 4'd0;
      repeat (3) @(posedge clk);
      #1 Reset = 1'b0;
      mon_en = 1'b1;
      start_xfer(4'd8); wait_done();
      start_xfer(4'd4); wait_done();
      start_xfer(4'd2); wait_done();
      start_xfer(4'd8);
      repeat (98) @(posedge clk);
      #1 Start = 1'b1; Log2n = 4'd4;
      @(posedge clk); #1 Start = 1'b0;
      wait_done();
      start_xfer(4'd8);
      repeat (198) @(posedge clk);
      #1 Reset = 1'b1;
      @(posedge clk); #1 Reset = 1'b0;
      q.delete(); dq.delete();
      repeat (3) @(posedge clk);
      #1 Reset = 1'b1; Start = 1'b1; Log2n = 4'd8;
      @(posedge clk); #1 Reset = 1'b0; Start = 1'b0;
      repeat (3) @(posedge clk);
      start_xfer(4'd8); wait_done();
      for (int i = 0; i < 8; i++) begin
         start_xfer(4'($urandom_range(0, 15)));
         wait_done();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
